// File: rtl/keccak_mask_pkg.sv
// Shared sizing for the masked Keccak datapath: share counts per bit and lane count.
// Used by the S-box wrappers and the compression stage so their widths always agree.
package keccak_mask_pkg;

    localparam int NLANE = 5;

    // Shares per bit after compression.
    function automatic int nsh(input int d);
        return d + 1;
    endfunction

    // Shares per bit at the S-box output, before compression.
    function automatic int nexp(input int d);
        return (d + 1) * (d + 1);
    endfunction

endpackage

// File: rtl/share_compress.sv
// Purpose: XOR each row of (d+1)^2 expanded shares down to d+1 shares for one lane.
// Latency: purely combinational. Backpressure: none, it has no state.
module share_compress
    import keccak_mask_pkg::*;
#(
    parameter int d = 1
) (
    input  logic [nexp(d)-1:0] exp_shares,
    output logic [nsh(d)-1:0]  cmp_shares
);

    localparam int NSH = nsh(d);

    always_comb begin
        cmp_shares = '0;
        for (int s = 0; s < NSH; s++) begin
            cmp_shares[s] = ^exp_shares[s*NSH +: NSH];
        end
    end

endmodule

// File: rtl/keccak_sbox_compress.sv
// Purpose: two-stage register/compress pipeline after the masked chi S-box; refresh via KECCAK_COMPRESS_REFRESH_EN.
// Latency: 2 cycles accept to valid_o, 1 item per cycle sustained.
// Backpressure: valid/ready; stalled stage B holds, A fills once, then ready_o drops.
module keccak_sbox_compress
    import keccak_mask_pkg::*;
#(
    parameter int d = 1
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [nexp(d)-1:0]      ap_i,
    input  logic [nexp(d)-1:0]      bp_i,
    input  logic [nexp(d)-1:0]      cp_i,
    input  logic [nexp(d)-1:0]      dp_i,
    input  logic [nexp(d)-1:0]      ep_i,
    input  logic [NLANE*nsh(d)-1:0] r_ref,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [nsh(d)-1:0]       ao,
    output logic [nsh(d)-1:0]       bo,
    output logic [nsh(d)-1:0]       co,
    output logic [nsh(d)-1:0]       do_o,
    output logic [nsh(d)-1:0]       eo
);

    localparam int NSH  = nsh(d);
    localparam int NEXP = nexp(d);

    typedef logic [NLANE-1:0][NEXP-1:0] exp_lanes_t;
    typedef logic [NLANE-1:0][NSH-1:0]  cmp_lanes_t;

    exp_lanes_t in_lanes;
    exp_lanes_t a_d, a_q;
    cmp_lanes_t cmp_lanes;
    cmp_lanes_t mask_mix;
    cmp_lanes_t b_d, b_q;
    logic       v_a_d, v_a_q;
    logic       v_b_d, v_b_q;
    logic       en_a, en_b;

    assign in_lanes = {ep_i, dp_i, cp_i, bp_i, ap_i};

    assign en_b    = !v_b_q || ready_i;
    assign en_a    = !v_a_q || en_b;
    assign ready_o = en_a;

    // The XOR trees only ever see stage-A flops, which act as the glitch barrier.
    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        share_compress #(.d(d)) u_share_compress (
            .exp_shares (a_q[k]),
            .cmp_shares (cmp_lanes[k])
        );
    end

`ifdef KECCAK_COMPRESS_REFRESH_EN
    // Each mask bit enters two neighbouring shares, so the unshared value is unchanged.
    always_comb begin
        mask_mix = '0;
        for (int k = 0; k < NLANE; k++) begin
            for (int s = 0; s < NSH; s++) begin
                mask_mix[k][s] = r_ref[k*NSH + s] ^ r_ref[k*NSH + ((s + 1) % NSH)];
            end
        end
    end
`else
    logic unused_r_ref;
    assign unused_r_ref = ^r_ref;
    assign mask_mix     = '0;
`endif

    always_comb begin
        v_a_d = v_a_q;
        a_d   = a_q;
        if (en_a) begin
            v_a_d = valid_i;
            if (valid_i) begin
                a_d = in_lanes;
            end
        end
    end

    always_comb begin
        v_b_d = v_b_q;
        b_d   = b_q;
        if (en_b) begin
            v_b_d = v_a_q;
            if (v_a_q) begin
                b_d = cmp_lanes ^ mask_mix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            v_a_q <= 1'b0;
            v_b_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            v_a_q <= v_a_d;
            v_b_q <= v_b_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign valid_o = v_b_q;
    assign ao      = b_q[0];
    assign bo      = b_q[1];
    assign co      = b_q[2];
    assign do_o    = b_q[3];
    assign eo      = b_q[4];

endmodule

// File: tb/tb_keccak_sbox_compress.sv
// Bench for keccak_sbox_compress: directed cases plus randomized traffic against a queue model.
// The model treats the block as a 2-deep in-order buffer whose items become visible 2 edges after acceptance.
module tb_keccak_sbox_compress;

    localparam int D     = 1;
    localparam int NSH   = D + 1;
    localparam int NEXP  = (D + 1) * (D + 1);
    localparam int NL    = 5;
    localparam int XW    = NL * NEXP;
    localparam int OW    = NL * NSH;
`ifdef KECCAK_COMPRESS_REFRESH_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    typedef logic [XW-1:0] xin_t;
    typedef logic [OW-1:0] xout_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic          valid_o;
    logic          ready_i;
    xin_t          in_x;
    xout_t         r_ref_t;
    logic [NSH-1:0] ao, bo, co, do_o, eo;
    xout_t         dut_out;

    assign dut_out = {eo, do_o, co, bo, ao};

    keccak_sbox_compress #(.d(D)) dut (
        .clk     (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .ap_i    (in_x[0*NEXP +: NEXP]),
        .bp_i    (in_x[1*NEXP +: NEXP]),
        .cp_i    (in_x[2*NEXP +: NEXP]),
        .dp_i    (in_x[3*NEXP +: NEXP]),
        .ep_i    (in_x[4*NEXP +: NEXP]),
        .r_ref   (r_ref_t),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .ao      (ao),
        .bo      (bo),
        .co      (co),
        .do_o    (do_o),
        .eo      (eo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_out  = 0;
    int first_out_cyc = -1;
    int last_out_cyc  = -1;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: each output share is the XOR of its row of expanded shares, plus optional mask pair.
    function automatic xout_t model_out(input xin_t x, input xout_t m);
        xout_t r;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            for (int s = 0; s < NSH; s++) begin
                logic b;
                b = 1'b0;
                for (int j = 0; j < NSH; j++) b = b ^ x[k*NEXP + s*NSH + j];
                if (REF_EN) b = b ^ m[k*NSH + s] ^ m[k*NSH + ((s + 1) % NSH)];
                r[k*NSH + s] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [NL-1:0] unshared_in(input xin_t x);
        logic [NL-1:0] r;
        for (int k = 0; k < NL; k++) r[k] = ^x[k*NEXP +: NEXP];
        return r;
    endfunction

    function automatic logic [NL-1:0] unshared_out(input xout_t o);
        logic [NL-1:0] r;
        for (int k = 0; k < NL; k++) r[k] = ^o[k*NSH +: NSH];
        return r;
    endfunction

    typedef struct {
        xin_t  x;
        xout_t m;
        int    acc;
        bit    smp;
    } ent_t;

    ent_t q[$];

    always @(negedge clk) begin
        bit    exp_v;
        bit    pop;
        int    tgt;
        ent_t  e;
        if (mon_en) begin
            exp_v = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
            chk("valid_o", valid_o, exp_v);
            chk("ready_o", ready_o, !(q.size() >= 2 && !ready_i));
            if (exp_v && valid_o) begin
                chk("data", dut_out, model_out(q[0].x, q[0].m));
                chk("unshared", unshared_out(dut_out), unshared_in(q[0].x));
            end
            if (rst_i) begin
                q.delete();
            end else begin
                pop = exp_v && ready_i;
                if (pop) begin
                    n_out++;
                    last_out_cyc = cyc;
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                end
                // Whichever item is in flight into the output stage this edge samples r_ref now.
                tgt = pop ? 1 : 0;
                if (q.size() > tgt && !q[tgt].smp && (cyc - q[tgt].acc) >= 1) begin
                    q[tgt].m   = r_ref_t;
                    q[tgt].smp = 1'b1;
                end
                if (pop) void'(q.pop_front());
                if (valid_i && ready_o) begin
                    e.x   = in_x;
                    e.m   = '0;
                    e.acc = cyc;
                    e.smp = 1'b0;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples the handshake mid-cycle, then advances past the next rising edge.
    task automatic step(output bit acc, output bit rdy, output int c);
        @(negedge clk);
        acc = valid_i && ready_o;
        rdy = ready_o;
        c   = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        xin_t  lit_x;
        xout_t lit_r;
        xout_t lit_exp;
        bit    acc, rdy, saw_low, rdy_low, got_first;
        int    c, c0, sent, stall_left, base_out;

        // Reset with valid_i high for two cycles.
        rst_i   = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b1;
        in_x    = xin_t'({$urandom(), $urandom()});
        r_ref_t = '0;
        tick();
        mon_en = 1'b1;
        tick();
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_outputs", dut_out, '0);
        chk("rst_ready_o", ready_o, 1'b1);
        rst_i   = 1'b0;
        valid_i = 1'b0;
        base_out = n_out;
        repeat (3) tick();
        chk("post_rst_idle", n_out - base_out, 0);
        chk("post_rst_valid_o", valid_o, 1'b0);

        // Compression literal case; lane a carries mask 01 which only matters with refresh.
        lit_x   = 20'h801F6;
        lit_r   = 10'b00_00_00_00_01;
        lit_exp = REF_EN ? 10'b10_00_01_00_00 : 10'b10_00_01_00_11;
        chk("model_pin_t2", model_out(lit_x, lit_r), lit_exp);
        chk("model_pin_ones", model_out(20'hFFFFF, '0), '0);
        in_x    = lit_x;
        r_ref_t = lit_r;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        in_x    = '0;
        tick();
        chk("t2_valid_o", valid_o, 1'b1);
        chk("t2_outputs", dut_out, lit_exp);
        chk("t2_lane_a_unshared", ^ao, 1'b0);
        tick();
        r_ref_t = '0;

        // Backpressure: 4 items, ready_i low for 3 cycles after the first output.
        base_out   = n_out;
        sent       = 0;
        stall_left = 0;
        saw_low    = 1'b0;
        got_first  = 1'b0;
        in_x       = xin_t'({$urandom(), $urandom()});
        for (int i = 0; i < 30; i++) begin
            valid_i = (sent < 4);
            ready_i = (stall_left == 0);
            @(negedge clk);
            if (!ready_o) saw_low = 1'b1;
            acc = valid_i && ready_o;
            if (!got_first && valid_o && ready_i) begin
                got_first  = 1'b1;
                stall_left = 4;
            end
            @(posedge clk);
            #1;
            if (stall_left > 0) stall_left--;
            if (acc) begin
                sent++;
                in_x = xin_t'({$urandom(), $urandom()});
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk("bp_items_sent", sent, 4);
        chk("bp_items_out", n_out - base_out, 4);
        chk("bp_ready_dropped", saw_low, 1'b1);

        // Full rate: 16 items back to back, ready_i always high.
        repeat (2) tick();
        base_out      = n_out;
        first_out_cyc = -1;
        rdy_low       = 1'b0;
        c0            = -1;
        for (int i = 0; i < 16; i++) begin
            valid_i = 1'b1;
            in_x    = xin_t'({$urandom(), $urandom()});
            r_ref_t = xout_t'($urandom());
            step(acc, rdy, c);
            if (!rdy) rdy_low = 1'b1;
            if (c0 < 0) c0 = c;
        end
        valid_i = 1'b0;
        repeat (4) tick();
        chk("fr_count", n_out - base_out, 16);
        chk("fr_first_latency", first_out_cyc - c0, 2);
        chk("fr_consecutive", last_out_cyc - first_out_cyc, 15);
        chk("fr_ready_high", rdy_low, 1'b0);

        // Reset with both stages full: nothing from before reset may appear.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            in_x    = xin_t'({$urandom(), $urandom()});
            tick();
        end
        chk("mid_full_ready_o", ready_o, 1'b0);
        chk("mid_full_valid_o", valid_o, 1'b1);
        rst_i   = 1'b1;
        ready_i = 1'b1;
        tick();
        chk("mid_rst_valid_o", valid_o, 1'b0);
        rst_i    = 1'b0;
        valid_i  = 1'b0;
        base_out = n_out;
        repeat (5) tick();
        chk("mid_rst_no_leak", n_out - base_out, 0);

        // Randomized traffic with occasional resets.
        base_out = n_out;
        for (int i = 0; i < 3000; i++) begin
            rst_i   = ($urandom_range(0, 299) == 0);
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = ($urandom_range(0, 9) < 7);
            in_x    = xin_t'({$urandom(), $urandom()});
            r_ref_t = xout_t'($urandom());
            tick();
        end
        rst_i   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (6) tick();
        chk("rand_activity", (n_out - base_out) > 1000, 1'b1);
        chk("rand_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
